// File: rtl/lc3_control_unit.sv
// LC-3 lab-6 sequencing/decode FSM: one state per clock, Moore control outputs
// for the datapath and SRAM strobes, with MEM_WAIT-cycle memory access states.
module lc3_control_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE_N,
  output logic       Mem_WE_N
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    HALTED = 5'd0,  S18 = 5'd1,  S33 = 5'd2,  S35 = 5'd3,  S32 = 5'd4,
    S01    = 5'd5,  S05 = 5'd6,  S09 = 5'd7,  S00 = 5'd8,  S22 = 5'd9,
    S12    = 5'd10, S04 = 5'd11, S21 = 5'd12, S06 = 5'd13, S25 = 5'd14,
    S27    = 5'd15, S07 = 5'd16, S23 = 5'd17, S16 = 5'd18, PAUSE1 = 5'd19,
    PAUSE2 = 5'd20
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          wait_last;
  logic          we_n_dec;
  logic          ir11_unused;

  // JSR and JSRR share one state path, so IR[11] does not steer sequencing.
  assign ir11_unused = IR_11;
  assign wait_last   = (wait_cnt == WAIT_LAST);
  // Reset forces the write strobe off without waiting for the state decode.
  assign Mem_WE_N    = we_n_dec | ~Reset;

  // State and wait-counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic; the counter is zero on any wait-state entry.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    case (state)
      HALTED: if (Run) state_next = S18; else state_next = HALTED;
      S18:    state_next = S33;
      S33, S25, S16: begin
        if (wait_last) begin
          case (state)
            S33:     state_next = S35;
            S25:     state_next = S27;
            default: state_next = S18;
          endcase
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      S35:    state_next = S32;
      S32: begin
        case (Opcode)
          4'b0001: state_next = S01;
          4'b0101: state_next = S05;
          4'b1001: state_next = S09;
          4'b0000: state_next = S00;
          4'b1100: state_next = S12;
          4'b0100: state_next = S04;
          4'b0110: state_next = S06;
          4'b0111: state_next = S07;
          4'b1101: state_next = PAUSE1;
          default: state_next = S18;
        endcase
      end
      S00:    if (BEN) state_next = S22; else state_next = S18;
      S04:    state_next = S21;
      S06:    state_next = S25;
      S07:    state_next = S23;
      S23:    state_next = S16;
      S01, S05, S09, S22, S12, S21, S27: state_next = S18;
      PAUSE1: if (Continue) state_next = PAUSE2; else state_next = PAUSE1;
      PAUSE2: if (Continue) state_next = PAUSE2; else state_next = S18;
      default: state_next = HALTED;
    endcase
  end

  // Moore decode of the control word.
  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00; MIO_EN = 1'b0;
    Mem_OE_N = 1'b1; we_n_dec = 1'b1;
    case (state)
      S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b00; LD_PC = 1'b1;
      end
      S33, S25: begin
        Mem_OE_N = 1'b0;
        if (wait_last) begin
          MIO_EN = 1'b1; LD_MDR = 1'b1;
        end else begin
          MIO_EN = 1'b0;
        end
      end
      S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S32: LD_BEN = 1'b1;
      S01, S05, S09: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        if (state == S01)      ALUK = 2'b00;
        else if (state == S05) ALUK = 2'b01;
        else                   ALUK = 2'b10;
      end
      S22: begin
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S12: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S21: begin
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S06, S07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S23: begin
        SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; MIO_EN = 1'b0; LD_MDR = 1'b1;
      end
      S16: we_n_dec = 1'b0;
      default: begin
        LD_MAR = 1'b0;
      end
    endcase
  end

endmodule
